// File: rtl/overlay_mac_pkg.sv
// Shared constants, S3 state type and ACC_W saturation bounds for the overlay MAC.
package overlay_mac_pkg;

    localparam int DEF_A_W    = 27;
    localparam int DEF_B_W    = 18;
    localparam int DEF_ACC_W  = 48;
    localparam int DEF_CNT_W  = 8;
    localparam int SAT_CALC_W = 128;

    typedef enum logic {
        ST_FIRST = 1'b0,
        ST_ACC   = 1'b1
    } mac_state_e;

    // Bounds are returned wide; callers keep the low w bits.
    function automatic logic [SAT_CALC_W-1:0] acc_max(input int w);
        return (SAT_CALC_W'(1) << (w - 1)) - SAT_CALC_W'(1);
    endfunction

    function automatic logic [SAT_CALC_W-1:0] acc_min(input int w);
        return ~acc_max(w);
    endfunction

endpackage

// File: rtl/overlay_mac_if.sv
// Operand/result bundle of the overlay MAC; master drives terms, slave returns results.
interface overlay_mac_if import overlay_mac_pkg::*; #(
    parameter int A_W   = DEF_A_W,
    parameter int B_W   = DEF_B_W,
    parameter int ACC_W = DEF_ACC_W,
    parameter int CNT_W = DEF_CNT_W
);
    logic                    in_valid;
    logic                    in_last;
    logic signed [A_W-1:0]   a;
    logic signed [B_W-1:0]   b;
    logic signed [ACC_W-1:0] pcin;
    logic                    cin;
    logic                    out_valid;
    logic signed [ACC_W-1:0] s;
    logic                    cout;
    logic                    ovf;
    logic [CNT_W-1:0]        term_cnt;

    modport master (
        output in_valid, in_last, a, b, pcin, cin,
        input  out_valid, s, cout, ovf, term_cnt
    );

    modport slave (
        input  in_valid, in_last, a, b, pcin, cin,
        output out_valid, s, cout, ovf, term_cnt
    );
endinterface

// File: rtl/overlay_mac_mult.sv
// Stages S1 (operand capture) and S2 (registered signed product) with valid/last tracking.
module overlay_mac_mult import overlay_mac_pkg::*; #(
    parameter int A_W = DEF_A_W,
    parameter int B_W = DEF_B_W,
    localparam int P_W = A_W + B_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    input  logic                  in_last,
    input  logic signed [A_W-1:0] a,
    input  logic signed [B_W-1:0] b,
    output logic                  vld_p2,
    output logic                  last_p2,
    output logic signed [P_W-1:0] prod_p2
);
    logic signed [A_W-1:0] a_p1;
    logic signed [B_W-1:0] b_p1;
    logic                  vld_p1;
    logic                  last_p1;

    // S1: operand capture
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_p1  <= 1'b0;
            last_p1 <= 1'b0;
            a_p1    <= '0;
            b_p1    <= '0;
        end else begin
            vld_p1  <= in_valid & ~flush;
            last_p1 <= in_valid & in_last;
            if (in_valid) begin
                a_p1 <= a;
                b_p1 <= b;
            end
        end
    end

    // S2: full-precision signed product
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_p2  <= 1'b0;
            last_p2 <= 1'b0;
            prod_p2 <= '0;
        end else begin
            vld_p2  <= vld_p1 & ~flush;
            last_p2 <= last_p1;
            if (vld_p1) begin
                prod_p2 <= P_W'(a_p1) * P_W'(b_p1);
            end
        end
    end
endmodule

// File: rtl/overlay_mac_pipe.sv
// Pipelined signed MAC: S1/S2 in overlay_mac_mult, S3 accumulate + cascade add here.
// Define OVERLAY_MAC_SAT_EN to clamp accumulate and cascade adds instead of wrapping.
module overlay_mac_pipe import overlay_mac_pkg::*; #(
    parameter int A_W   = DEF_A_W,
    parameter int B_W   = DEF_B_W,
    parameter int ACC_W = DEF_ACC_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    overlay_mac_if.slave bus
);
    localparam int P_W = A_W + B_W;
    localparam logic [SAT_CALC_W-1:0] MAX_WIDE = acc_max(ACC_W);
    localparam logic [SAT_CALC_W-1:0] MIN_WIDE = acc_min(ACC_W);
    localparam logic signed [ACC_W-1:0] ACC_MAX = MAX_WIDE[ACC_W-1:0];
    localparam logic signed [ACC_W-1:0] ACC_MIN = MIN_WIDE[ACC_W-1:0];

`ifdef OVERLAY_MAC_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    // Sums are formed one bit wider; the top two bits differ exactly on overflow.
    function automatic logic ovf_wide(input logic [1:0] top);
        return top[1] ^ top[0];
    endfunction

    function automatic logic signed [ACC_W-1:0] sat_wide(input logic signed [ACC_W:0] v);
        if (v[ACC_W] == v[ACC_W-1]) return v[ACC_W-1:0];
        else if (v[ACC_W])          return ACC_MIN;
        else                        return ACC_MAX;
    endfunction

    logic                    vld_p2;
    logic                    last_p2;
    logic signed [P_W-1:0]   prod_p2;

    mac_state_e              state, state_nxt;
    logic                    first;
    logic signed [ACC_W-1:0] acc, acc_base, acc_new, prod_ext, s_new;
    logic signed [ACC_W:0]   acc_sum, fin_sum;
    logic                    ovf_acc, ovf_base, ovf_new, ovf_fin, fin_ovf, cout_new;
    logic [CNT_W-1:0]        cnt, cnt_base, cnt_new;

    overlay_mac_mult #(.A_W(A_W), .B_W(B_W)) u_mult (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .in_valid (bus.in_valid),
        .in_last  (bus.in_last),
        .a        (bus.a),
        .b        (bus.b),
        .vld_p2   (vld_p2),
        .last_p2  (last_p2),
        .prod_p2  (prod_p2)
    );

    assign prod_ext = ACC_W'(prod_p2);

    always_comb begin
        state_nxt = state;
        first     = (state == ST_FIRST);
        acc_base  = first ? '0 : acc;
        ovf_base  = first ? 1'b0 : ovf_acc;
        cnt_base  = first ? '0 : cnt;

        acc_sum = {acc_base[ACC_W-1], acc_base} + {prod_ext[ACC_W-1], prod_ext};
        acc_new = SAT_EN ? sat_wide(acc_sum) : acc_sum[ACC_W-1:0];
        ovf_new = ovf_base | ovf_wide(acc_sum[ACC_W -: 2]);
        cnt_new = (&cnt_base) ? cnt_base : cnt_base + CNT_W'(1);

        fin_sum = {acc_new[ACC_W-1], acc_new} + {bus.pcin[ACC_W-1], bus.pcin}
                + (ACC_W+1)'(bus.cin);
        fin_ovf = ovf_wide(fin_sum[ACC_W -: 2]);
        s_new   = SAT_EN ? sat_wide(fin_sum) : fin_sum[ACC_W-1:0];
        ovf_fin = ovf_new | fin_ovf;
        // Unsigned carry recovered from the sign-extended sum: top bit = sa ^ sp ^ carry.
        cout_new = (SAT_EN && fin_ovf) ? 1'b0
                 : fin_sum[ACC_W] ^ acc_new[ACC_W-1] ^ bus.pcin[ACC_W-1];

        if (vld_p2) state_nxt = last_p2 ? ST_FIRST : ST_ACC;
        if (flush)  state_nxt = ST_FIRST;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_FIRST;
        else        state <= state_nxt;
    end

    // S3: accumulate, cascade add, result registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc          <= '0;
            ovf_acc      <= 1'b0;
            cnt          <= '0;
            bus.out_valid <= 1'b0;
            bus.s        <= '0;
            bus.cout     <= 1'b0;
            bus.ovf      <= 1'b0;
            bus.term_cnt <= '0;
        end else if (flush) begin
            acc          <= '0;
            ovf_acc      <= 1'b0;
            cnt          <= '0;
            bus.out_valid <= 1'b0;
        end else begin
            bus.out_valid <= vld_p2 & last_p2;
            if (vld_p2) begin
                acc     <= acc_new;
                ovf_acc <= ovf_new;
                cnt     <= cnt_new;
                if (last_p2) begin
                    bus.s        <= s_new;
                    bus.cout     <= cout_new;
                    bus.ovf      <= ovf_fin;
                    bus.term_cnt <= cnt_new;
                end
            end
        end
    end
endmodule

// File: tb/tb_overlay_mac_pipe.sv
// Directed bench for overlay_mac_pipe; honours OVERLAY_MAC_SAT_EN for the overflow case.
module tb_overlay_mac_pipe;
    localparam int A_W = 27, B_W = 18, ACC_W = 48, CNT_W = 8;

    typedef struct {
        int               cyc;
        logic [ACC_W-1:0] s;
        logic             cout;
        logic             ovf;
        logic [CNT_W-1:0] cnt;
    } rec_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic flush = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   last_cyc = 0;
    logic [ACC_W-1:0] exp_hold;
    rec_t q[$];

    always #5 clk = ~clk;

    overlay_mac_if #(.A_W(A_W), .B_W(B_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) bus ();

    overlay_mac_pipe #(.A_W(A_W), .B_W(B_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        rec_t r;
        if (bus.out_valid === 1'b1) begin
            r.cyc  = cyc;
            r.s    = bus.s;
            r.cout = bus.cout;
            r.ovf  = bus.ovf;
            r.cnt  = bus.term_cnt;
            q.push_back(r);
        end
    end

    task automatic drive(input int av, input int bv, input logic lst);
        bus.in_valid = 1'b1;
        bus.a        = A_W'(av);
        bus.b        = B_W'(bv);
        bus.in_last  = lst;
        last_cyc     = cyc;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic settle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset.out_valid: got %b want 0", bus.out_valid); end
        n_tests++; if (bus.s !== '0) begin n_fail++; $display("FAIL reset.s: got %h want 0", bus.s); end
        n_tests++; if (bus.cout !== 1'b0) begin n_fail++; $display("FAIL reset.cout: got %b want 0", bus.cout); end
        n_tests++; if (bus.ovf !== 1'b0) begin n_fail++; $display("FAIL reset.ovf: got %b want 0", bus.ovf); end
        n_tests++; if (bus.term_cnt !== '0) begin n_fail++; $display("FAIL reset.term_cnt: got %0d want 0", bus.term_cnt); end
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        rec_t r;
        q.delete();
        bus.pcin = ACC_W'(10);
        bus.cin  = 1'b1;
        drive(3, 4, 1'b1);
        settle(5);
        n_tests++;
        if (q.size() != 1) begin n_fail++; $display("FAIL single.count: got %0d want 1", q.size()); end
        else begin
            r = q[0];
            n_tests++; if (r.cyc - last_cyc != 3) begin n_fail++; $display("FAIL single.latency: got %0d want 3", r.cyc - last_cyc); end
            n_tests++; if (r.s !== ACC_W'(23)) begin n_fail++; $display("FAIL single.s: got %0d want 23", $signed(r.s)); end
            n_tests++; if (r.cout !== 1'b0) begin n_fail++; $display("FAIL single.cout: got %b want 0", r.cout); end
            n_tests++; if (r.ovf !== 1'b0) begin n_fail++; $display("FAIL single.ovf: got %b want 0", r.ovf); end
            n_tests++; if (r.cnt !== CNT_W'(1)) begin n_fail++; $display("FAIL single.term_cnt: got %0d want 1", r.cnt); end
        end
        n_tests++; if (bus.s !== ACC_W'(23)) begin n_fail++; $display("FAIL single.hold: got %0d want 23", $signed(bus.s)); end
        bus.pcin = '0;
        bus.cin  = 1'b0;
    endtask

    task automatic test_vector4();
        rec_t r;
        q.delete();
        for (int i = 0; i < 4; i++) drive(-2, 5, i == 3);
        settle(5);
        n_tests++;
        if (q.size() != 1) begin n_fail++; $display("FAIL vec4.count: got %0d want 1", q.size()); end
        else begin
            r = q[0];
            n_tests++; if (r.s !== ACC_W'(-40)) begin n_fail++; $display("FAIL vec4.s: got %0d want -40", $signed(r.s)); end
            n_tests++; if (r.cnt !== CNT_W'(4)) begin n_fail++; $display("FAIL vec4.term_cnt: got %0d want 4", r.cnt); end
            n_tests++; if (r.ovf !== 1'b0) begin n_fail++; $display("FAIL vec4.ovf: got %b want 0", r.ovf); end
        end
    endtask

    task automatic test_carry();
        rec_t r;
        q.delete();
        bus.pcin = ACC_W'(1);
        drive(-1, 1, 1'b1);
        settle(5);
        n_tests++;
        if (q.size() != 1) begin n_fail++; $display("FAIL carry.count: got %0d want 1", q.size()); end
        else begin
            r = q[0];
            n_tests++; if (r.s !== '0) begin n_fail++; $display("FAIL carry.s: got %0d want 0", $signed(r.s)); end
            n_tests++; if (r.cout !== 1'b1) begin n_fail++; $display("FAIL carry.cout: got %b want 1", r.cout); end
            n_tests++; if (r.ovf !== 1'b0) begin n_fail++; $display("FAIL carry.ovf: got %b want 0", r.ovf); end
        end
        bus.pcin = '0;
    endtask

    task automatic test_back_to_back();
        q.delete();
        drive(2, 3, 1'b1);
        drive(7, 7, 1'b1);
        settle(5);
        n_tests++;
        if (q.size() != 2) begin n_fail++; $display("FAIL b2b.count: got %0d want 2", q.size()); end
        else begin
            n_tests++; if (q[0].s !== ACC_W'(6)) begin n_fail++; $display("FAIL b2b.s0: got %0d want 6", $signed(q[0].s)); end
            n_tests++; if (q[1].s !== ACC_W'(49)) begin n_fail++; $display("FAIL b2b.s1: got %0d want 49", $signed(q[1].s)); end
            n_tests++; if (q[1].cyc != q[0].cyc + 1) begin n_fail++; $display("FAIL b2b.spacing: got %0d want 1", q[1].cyc - q[0].cyc); end
            n_tests++; if (q[1].cnt !== CNT_W'(1)) begin n_fail++; $display("FAIL b2b.term_cnt: got %0d want 1", q[1].cnt); end
        end
    endtask

    task automatic test_overflow();
        rec_t r;
        longint p;
        logic [ACC_W-1:0] exp_s;
        p = longint'(67108863) * longint'(131071);
`ifdef OVERLAY_MAC_SAT_EN
        exp_s = {1'b0, {(ACC_W-1){1'b1}}};
`else
        exp_s = ACC_W'(p * 17);
`endif
        q.delete();
        for (int i = 0; i < 17; i++) drive(67108863, 131071, i == 16);
        settle(5);
        n_tests++;
        if (q.size() != 1) begin n_fail++; $display("FAIL ovf.count: got %0d want 1", q.size()); end
        else begin
            r = q[0];
            n_tests++; if (r.s !== exp_s) begin n_fail++; $display("FAIL ovf.s: got %h want %h", r.s, exp_s); end
            n_tests++; if (r.ovf !== 1'b1) begin n_fail++; $display("FAIL ovf.ovf: got %b want 1", r.ovf); end
            n_tests++; if (r.cout !== 1'b0) begin n_fail++; $display("FAIL ovf.cout: got %b want 0", r.cout); end
            n_tests++; if (r.cnt !== CNT_W'(17)) begin n_fail++; $display("FAIL ovf.term_cnt: got %0d want 17", r.cnt); end
        end
        exp_hold = exp_s;
    endtask

    task automatic test_flush();
        rec_t r;
        q.delete();
        drive(4, 4, 1'b0);
        drive(5, 5, 1'b0);
        flush        = 1'b1;
        bus.in_valid = 1'b1;
        bus.a        = A_W'(9);
        bus.b        = B_W'(9);
        bus.in_last  = 1'b1;
        @(posedge clk); #1;
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        n_tests++; if (bus.s !== exp_hold) begin n_fail++; $display("FAIL flush.hold: got %h want %h", bus.s, exp_hold); end
        drive(1, 1, 1'b1);
        settle(6);
        n_tests++;
        if (q.size() != 1) begin n_fail++; $display("FAIL flush.count: got %0d want 1", q.size()); end
        else begin
            r = q[0];
            n_tests++; if (r.s !== ACC_W'(1)) begin n_fail++; $display("FAIL flush.s: got %0d want 1", $signed(r.s)); end
            n_tests++; if (r.cnt !== CNT_W'(1)) begin n_fail++; $display("FAIL flush.term_cnt: got %0d want 1", r.cnt); end
            n_tests++; if (r.ovf !== 1'b0) begin n_fail++; $display("FAIL flush.ovf: got %b want 0", r.ovf); end
        end
    endtask

    task automatic test_cnt_sat();
        rec_t r;
        q.delete();
        for (int i = 0; i < 260; i++) drive(1, 1, i == 259);
        settle(5);
        n_tests++;
        if (q.size() != 1) begin n_fail++; $display("FAIL cntsat.count: got %0d want 1", q.size()); end
        else begin
            r = q[0];
            n_tests++; if (r.s !== ACC_W'(260)) begin n_fail++; $display("FAIL cntsat.s: got %0d want 260", $signed(r.s)); end
            n_tests++; if (r.cnt !== CNT_W'(255)) begin n_fail++; $display("FAIL cntsat.term_cnt: got %0d want 255", r.cnt); end
        end
    endtask

    task automatic test_reset_mid();
        rec_t r;
        q.delete();
        drive(3, 3, 1'b0);
        drive(3, 3, 1'b0);
        #2 reset = 1'b0;
        #1;
        n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid.out_valid: got %b want 0", bus.out_valid); end
        n_tests++; if (bus.s !== '0) begin n_fail++; $display("FAIL rstmid.s: got %h want 0", bus.s); end
        n_tests++; if (bus.term_cnt !== '0) begin n_fail++; $display("FAIL rstmid.term_cnt: got %0d want 0", bus.term_cnt); end
        n_tests++; if (bus.ovf !== 1'b0 || bus.cout !== 1'b0) begin n_fail++; $display("FAIL rstmid.flags: got ovf=%b cout=%b want 0 0", bus.ovf, bus.cout); end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        drive(5, 5, 1'b1);
        settle(5);
        n_tests++;
        if (q.size() != 1) begin n_fail++; $display("FAIL rstmid.count: got %0d want 1", q.size()); end
        else begin
            r = q[0];
            n_tests++; if (r.s !== ACC_W'(25)) begin n_fail++; $display("FAIL rstmid.s25: got %0d want 25", $signed(r.s)); end
            n_tests++; if (r.cnt !== CNT_W'(1)) begin n_fail++; $display("FAIL rstmid.cnt1: got %0d want 1", r.cnt); end
        end
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.a        = '0;
        bus.b        = '0;
        bus.pcin     = '0;
        bus.cin      = 1'b0;
        exp_hold     = '0;
        test_reset();
        test_single();
        test_vector4();
        test_carry();
        test_back_to_back();
        test_overflow();
        test_flush();
        test_cnt_sat();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
